restoring_divider_16: RTL and testbench

Iterative unsigned restoring divider: the inverse-operation companion to the team's carry-lookahead adders and fast multipliers. It accepts a dividend/divisor pair over a valid/ready handshake and produces quotient and remainder after WIDTH iterations, one quotient bit per cycle, MSB first. Each trial subtraction uses a (WIDTH+1)-bit carry-lookahead subtractor built as add-with-inverted-operand. It sits beside the multiplier datapaths as the division unit.

---
 rtl/divider_pkg.sv | 24 ++
 rtl/cla_subtractor.sv | 35 +++
 rtl/restoring_divider_16.sv | 127 ++++++++++++
 tb/tb_restoring_divider_16.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// divider_pkg: shared definitions for the iterative restoring divider.
//   state_e       - FSM state encoding (IDLE/BUSY/DONE)
//   DEFAULT_WIDTH - default operand/result width
//   clog2()       - width helper used to size the iteration counter
package divider_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    // Ceiling log2; the counter must hold the value WIDTH, so callers
    // pass WIDTH+1.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res++;
        return res;
    endfunction

endpackage

// File: rtl/cla_subtractor.sv
// cla_subtractor: N-bit carry-lookahead subtractor, a - b, computed as
// a + ~b + 1.
//   a_i    [N-1:0]  minuend
//   b_i    [N-1:0]  subtrahend
//   diff_o [N-1:0]  a - b (mod 2^N)
//   cout_o          carry out; 1 means no borrow (a >= b)
module cla_subtractor #(
    parameter int N = 17
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    output logic [N-1:0] diff_o,
    output logic         cout_o
);

    logic [N-1:0] gen;
    logic [N-1:0] prop;
    logic [N:0]   carry;

    // Generate/propagate against the inverted subtrahend.
    assign gen  = a_i & ~b_i;
    assign prop = a_i ^ ~b_i;

    // Lookahead recurrence seeded with cin=1 (the +1 of two's complement).
    always_comb begin
        carry[0] = 1'b1;
        for (int i = 0; i < N; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign diff_o = prop ^ carry[N-1:0];
    assign cout_o = carry[N];

endmodule

// File: rtl/restoring_divider_16.sv
// restoring_divider_16: iterative unsigned restoring divider, one quotient
// bit per cycle, MSB first.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready = idle)
//   dividend, divisor     WIDTH-bit unsigned operands
//   out_valid / out_ready result handshake (out_valid = result held)
//   quotient, remainder   WIDTH-bit unsigned results
//   div_by_zero           result came from a zero divisor
module restoring_divider_16
    import divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             no_borrow;

    // Partial remainder shifted left with the next dividend bit pulled in.
    assign trial = {r_q, q_q[WIDTH-1]};

    cla_subtractor #(.N(WIDTH + 1)) u_sub (
        .a_i    (trial),
        .b_i    ({1'b0, d_q}),
        .diff_o (diff),
        .cout_o (no_borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    d_d   = divisor;
                    q_d   = dividend;
                    r_d   = '0;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        // Zero divisor skips iteration entirely.
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                // Restore (keep the unsubtracted trial) when the subtract borrows.
                r_d   = no_borrow ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], no_borrow};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    quot_d  = q_d;
                    rem_d   = r_d;
                    dbz_d   = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_16.sv
module tb_restoring_divider_16;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int tests = 0;
    int fails = 0;

    restoring_divider_16 #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction checked against plain integer division.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input bit poke_busy);
        int          lat;
        int          guard;
        logic [31:0] eq, er, ed;
        if (b == 0) begin
            eq = 32'hFFFF; er = 32'(a); ed = 1;
        end else begin
            eq = 32'(a) / 32'(b); er = 32'(a) % 32'(b); ed = 0;
        end

        guard = 0;
        while (!in_ready && guard < 50) begin
            tick(); guard++;
        end
        check("in_ready_before_issue", 32'(in_ready), 1);

        in_valid = 1'b1; dividend = a; divisor = b;
        tick();                                  // accepting edge
        in_valid = 1'b0;
        dividend = W'($urandom); divisor = W'($urandom);

        lat = 0;
        while (!out_valid && lat < 40) begin
            if (poke_busy) begin
                in_valid = lat[0];
                dividend = W'($urandom); divisor = W'($urandom);
            end
            tick(); lat++;
        end
        in_valid = 1'b0;
        check("latency", 32'(lat), (b == 0) ? 0 : W);

        check("quotient", 32'(quotient), eq);
        check("remainder", 32'(remainder), er);
        check("div_by_zero", 32'(div_by_zero), ed);
        if (b != 0) begin
            check("identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            check("rem_lt_div", 32'(remainder < b), 1);
        end

        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", 32'(out_valid), 1);
            check("hold_quotient", 32'(quotient), eq);
            check("hold_remainder", 32'(remainder), er);
            check("hold_dbz", 32'(div_by_zero), ed);
        end

        out_ready = 1'b1;
        tick();                                  // output handshake edge
        out_ready = 1'b0;
        check("in_ready_after_hs", 32'(in_ready), 1);
        check("out_valid_after_hs", 32'(out_valid), 0);
    endtask

    initial begin
        logic [W-1:0] a, b;
        int           sel;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        dividend = '0; divisor = '0;
        #12;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_quotient", 32'(quotient), 0);
        check("rst_remainder", 32'(remainder), 0);
        check("rst_dbz", 32'(div_by_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed cases.
        run_op(16'd100, 16'd7, 0, 1'b0);
        run_op(16'hFFFF, 16'd1, 0, 1'b0);
        run_op(16'hFFFF, 16'hFFFF, 0, 1'b0);
        run_op(16'd3, 16'd10, 0, 1'b0);
        run_op(16'd5, 16'd0, 0, 1'b0);
        run_op(16'd1000, 16'd33, 5, 1'b1);

        // Reset mid-iteration discards the operation.
        in_valid = 1'b1; dividend = 16'd50000; divisor = 16'd3;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_quotient", 32'(quotient), 0);
        check("midrst_remainder", 32'(remainder), 0);
        check("midrst_dbz", 32'(div_by_zero), 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("midrst_no_valid", 32'(out_valid), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op(16'd50000, 16'd3, 0, 1'b0);

        // Random pairs with random backpressure.
        for (int n = 0; n < 2000; n++) begin
            sel = $urandom_range(0, 7);
            a = W'($urandom);
            case (sel)
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 15));
                3:       begin b = W'($urandom_range(1, 65535)); a = W'($urandom_range(0, int'(b) - 1)); end
                default: b = W'($urandom);
            endcase
            run_op(a, b, $urandom_range(0, 3), $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
